mem_lsu_sbuf: RTL and testbench
===============================

// Module: mem_lsu_sbuf
// PURPOSE
//  Parametrised MEM-stage load/store unit with a posted store buffer.
//  Stores retire into a SB_DEPTH FIFO without stalling and drain to memory in the background.
//  Loads drain the buffer first for ordering, then issue. They return sign/zero-extended data.
//  Sits between the EXE->MEM pipeline register and the data-memory port. Drives the MEM stall.
// PARAMETERS
//  XLEN      32  datapath/memory bus width (32 or 64); byte lanes NB = XLEN/8
//  SB_DEPTH  4   store-buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        asynchronous, active-low reset
//  is_bubbling  in   1        MEM slot holds a bubble; request inputs ignored
//  req_read     in   1        load request (held stable by upstream while stall=1)
//  req_write    in   1        store request (mutually exclusive with req_read)
//  req_funct3   in   3        [1:0] size 0=B 1=H 2=W 3=D; [2] unsigned load
//  req_addr     in   XLEN     byte address
//  req_wdata    in   XLEN     store data, LSB-justified
//  stall        out  1        hold MEM and upstream stages this cycle
//  load_valid   out  1        one-cycle pulse: load_data valid
//  load_data    out  XLEN     extended load result
//  misalign     out  1        one-cycle pulse: request dropped (misaligned/illegal size)
//  sb_count     out  clog2(SB_DEPTH)+1  occupied entries
//  mem_read     out  1        memory read strobe, held until mem_resp
//  mem_write    out  1        memory write strobe, held until mem_resp
//  mem_address  out  XLEN     address aligned to NB bytes
//  mem_byte_en  out  NB       byte enables (loads: all ones)
//  mem_wdata    out  XLEN     lane-shifted store data
//  mem_resp     in   1        memory completion, single cycle
//  mem_rdata    in   XLEN     read data, valid with mem_resp
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, FIFO empty, all outputs 0. In-flight access and buffered stores are discarded.
//  Accept: request active iff (req_read|req_write) & ~is_bubbling.
//  Misalign: addr mod (1<<size) != 0, or size=3 with XLEN=32.
//    misalign=1 that cycle, no push/issue, stall=0.
//  Store: lane = addr[log2(NB)-1:0]; byte_en = ((1<<(1<<size))-1) << lane; wdata << 8*lane.
//    Pushes {aligned addr, data, byte_en} same edge when count<SB_DEPTH, stall=0.
//    If full: stall=1, push on the first edge where count<SB_DEPTH.
//    Push and pop on the same edge are legal; count is unchanged.
//  FSM states: IDLE, ST_DRAIN, LD_REQ, LD_DONE.
//    IDLE->ST_DRAIN when count>0.
//    IDLE->LD_REQ on an accepted load with count==0.
//    ST_DRAIN: mem_write=1 with head entry. On mem_resp pop, then ->ST_DRAIN if count-1>0, else IDLE.
//    LD_REQ: mem_read=1, byte_en all ones. On mem_resp register the extended rdata, ->LD_DONE.
//    LD_DONE: load_valid=1, stall=0, request consumed (no reissue), ->IDLE (or ST_DRAIN if count>0).
//  Load stall: stall=1 from the accepting cycle through the mem_resp cycle; released in LD_DONE.
//    A load while count>0 stalls until the buffer is fully drained (stores before loads, no forwarding).
//  Load latency: req at N with empty SB -> mem_read from N+1 -> resp at M -> load_valid at M+1.
//  Extend: field = rdata >> 8*lane, width 8<<size; sign-extend if funct3[2]=0, else zero-extend.
//  mem_read and mem_write are never both 1. Address/data/byte_en are stable while a strobe is high.
//  is_bubbling high during an in-flight load: the load completes and load_valid is still pulsed.
// TESTING
//  Reset mid-ST_DRAIN: drop rst with mem_write=1 -> mem_write=0 immediately, sb_count=0.
//  SB store 0xAABBCCDD at 0x102, funct3=001 -> byte_en=1100, mem_wdata=0xCCDD0000, addr=0x100, stall=0.
//  SB_DEPTH+1 back-to-back SW, mem_resp every 5 cycles -> 5th store stalls until first pop, then accepted.
//  LB at 0x103, rdata=0x80FFFFFF -> load_data=0xFFFFFF80; LBU -> 0x00000080; load_valid 1 cycle after resp.
//  2 SWs then LW to same addr -> 2 mem_write before mem_read; load returns the 2nd store's value.
//  LW at 0x102 -> misalign pulse, no mem strobe. is_bubbling=1 with req_write -> no push.

Source files
------------

// File: rtl/mem_lsu_sbuf.sv
// MEM-stage load/store unit: stores post into a small FIFO and drain in the background,
// loads wait for the FIFO to empty, then issue and return sign/zero-extended data.
module mem_lsu_sbuf #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        is_bubbling,
    input  logic                        req_read,
    input  logic                        req_write,
    input  logic [2:0]                  req_funct3,
    input  logic [XLEN-1:0]             req_addr,
    input  logic [XLEN-1:0]             req_wdata,
    output logic                        stall,
    output logic                        load_valid,
    output logic [XLEN-1:0]             load_data,
    output logic                        misalign,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [XLEN-1:0]             mem_address,
    output logic [XLEN/8-1:0]           mem_byte_en,
    output logic [XLEN-1:0]             mem_wdata,
    input  logic                        mem_resp,
    input  logic [XLEN-1:0]             mem_rdata
);

    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int PTR_W  = $clog2(SB_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ST_DRAIN,
        LD_REQ,
        LD_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [XLEN-1:0]   sb_addr_mem [SB_DEPTH];
    logic [XLEN-1:0]   sb_data_mem [SB_DEPTH];
    logic [NB-1:0]     sb_be_mem   [SB_DEPTH];

    logic [XLEN-1:0]   ld_addr_reg;
    logic [LANE_W-1:0] ld_lane_reg;
    logic [2:0]        ld_funct3_reg;
    logic [XLEN-1:0]   load_data_reg;

    // ---------------- request decode ----------------
    logic [1:0]        req_size;
    logic [LANE_W-1:0] req_lane;
    logic [3:0]        size_mask;
    logic              open_slot, req_active, req_bad;
    logic              st_req, ld_req, full, push, pop;
    logic [7:0]        be_base;
    logic [NB-1:0]     req_be;
    logic [XLEN-1:0]   req_aligned, req_wdata_lane;

    assign req_size   = req_funct3[1:0];
    assign req_lane   = req_addr[LANE_W-1:0];
    assign size_mask  = (4'd1 << req_size) - 4'd1;

    // The load being serviced owns the slot until LD_DONE consumes it, so the held
    // request lines are ignored there and cannot trigger a reissue.
    assign open_slot  = (state_reg == IDLE) || (state_reg == ST_DRAIN);
    assign req_active = (req_read | req_write) & ~is_bubbling & open_slot & rst;
    assign req_bad    = (({1'b0, req_addr[2:0]} & size_mask) != 4'd0) ||
                        ((XLEN == 32) && (req_size == 2'd3));

    assign misalign   = req_active & req_bad;
    assign st_req     = req_active & ~req_bad & req_write;
    assign ld_req     = req_active & ~req_bad & req_read & ~req_write;

    assign full       = (count_reg == CNT_W'(SB_DEPTH));
    assign push       = st_req & ~full;
    assign pop        = (state_reg == ST_DRAIN) & mem_resp;
    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        be_base = 8'h01;
        case (req_size)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            2'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
    end

    assign req_be         = NB'(be_base) << req_lane;
    assign req_wdata_lane = req_wdata << {req_lane, 3'b000};
    assign req_aligned    = {req_addr[XLEN-1:LANE_W], {LANE_W{1'b0}}};

    // ---------------- store buffer ----------------
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_sb_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    sb_addr_mem[gi] <= req_aligned;
                    sb_data_mem[gi] <= req_wdata_lane;
                    sb_be_mem[gi]   <= req_be;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // ---------------- load extension ----------------
    logic [XLEN-1:0] ld_shifted, ld_mask, ld_ext;
    logic            ld_sign;

    // A field as wide as the bus shifts the one out entirely, so the mask wraps to all ones.
    assign ld_shifted = mem_rdata >> {ld_lane_reg, 3'b000};
    assign ld_mask    = (XLEN'(1) << (7'd8 << ld_funct3_reg[1:0])) - XLEN'(1);
    assign ld_sign    = |(ld_shifted & (ld_mask ^ (ld_mask >> 1)));
    assign ld_ext     = (ld_shifted & ld_mask) |
                        ((~ld_funct3_reg[2] & ld_sign) ? ~ld_mask : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_addr_reg   <= '0;
            ld_lane_reg   <= '0;
            ld_funct3_reg <= '0;
            load_data_reg <= '0;
        end else begin
            if ((state_reg == IDLE) && (count_reg == '0) && ld_req) begin
                ld_addr_reg   <= req_aligned;
                ld_lane_reg   <= req_lane;
                ld_funct3_reg <= req_funct3;
            end
            if ((state_reg == LD_REQ) && mem_resp)
                load_data_reg <= ld_ext;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0)
                    state_next = ST_DRAIN;
                else if (ld_req)
                    state_next = LD_REQ;
            end
            ST_DRAIN: begin
                if (mem_resp)
                    state_next = (count_next != '0) ? ST_DRAIN : IDLE;
            end
            LD_REQ: begin
                if (mem_resp)
                    state_next = LD_DONE;
            end
            LD_DONE: begin
                state_next = (count_reg != '0) ? ST_DRAIN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A pending load stalls through the whole drain so stores always reach memory first.
    assign stall      = (st_req & full) | ld_req | (state_reg == LD_REQ);
    assign load_valid = (state_reg == LD_DONE);
    assign load_data  = load_data_reg;
    assign sb_count   = count_reg;

    assign mem_write   = (state_reg == ST_DRAIN);
    assign mem_read    = (state_reg == LD_REQ);
    assign mem_address = mem_write ? sb_addr_mem[rd_ptr_reg] :
                         (mem_read ? ld_addr_reg : '0);
    assign mem_byte_en = mem_write ? sb_be_mem[rd_ptr_reg] :
                         (mem_read ? '1 : '0);
    assign mem_wdata   = mem_write ? sb_data_mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_mem_lsu_sbuf.sv
// Scoreboard bench for mem_lsu_sbuf: a byte-level reference memory predicts every memory
// write, load address and load result; a memory slave and a monitor pop and compare.
module tb_mem_lsu_sbuf;

    localparam int XLEN     = 32;
    localparam int SB_DEPTH = 4;
    localparam int NB       = XLEN / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              is_bubbling = 1'b0, req_read = 1'b0, req_write = 1'b0;
    logic [2:0]        req_funct3 = '0;
    logic [XLEN-1:0]   req_addr = '0, req_wdata = '0;
    logic              stall, load_valid, misalign, mem_read, mem_write;
    logic [XLEN-1:0]   load_data, mem_address, mem_wdata;
    logic [$clog2(SB_DEPTH):0] sb_count;
    logic [NB-1:0]     mem_byte_en;
    logic              mem_resp = 1'b0;
    logic [XLEN-1:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    mem_lsu_sbuf #(.XLEN(XLEN), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .rst(rst), .is_bubbling(is_bubbling), .req_read(req_read),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .misalign(misalign), .sb_count(sb_count),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    int fixed_lat = -1;
    int wr_done = 0;
    int rd_resp_cyc = -10;

    logic [7:0]  ref_mem [int];
    logic [7:0]  slv_mem [int];
    logic [67:0] exp_wr [$];
    logic [31:0] exp_rd [$];
    logic [31:0] exp_ld [$];
    logic [31:0] exp_mis [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 37 + 90);
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] slv_rd(input int a);
        if (slv_mem.exists(a)) return slv_mem[a];
        return init_byte(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Memory slave: random or fixed latency, completes each strobe with a one-cycle mem_resp.
    initial begin : slave
        bit busy;
        int lat;
        bit waited;
        logic [31:0] cap_addr, cap_wdata, word;
        logic [3:0]  cap_be;
        logic [67:0] e;
        busy = 0; lat = 0; waited = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_resp) begin
                mem_resp  = 1'b0;
                mem_rdata = $urandom;
            end else if (!(mem_read || mem_write)) begin
                busy = 0;
            end else begin
                if (!busy) begin
                    busy = 1; waited = 0;
                    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    cap_addr = mem_address; cap_be = mem_byte_en; cap_wdata = mem_wdata;
                end
                if (lat == 0) begin
                    chk("rw_exclusive", 64'(mem_read & mem_write), 64'd0);
                    if (waited) begin
                        chk("strobe_stable", {mem_address, mem_byte_en, mem_wdata[27:0]},
                            {cap_addr, cap_be, cap_wdata[27:0]});
                    end
                    if (mem_write) begin
                        if (exp_wr.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL mem_write_unexpected: got addr 0x%0h be %b data 0x%0h, required none",
                                     mem_address, mem_byte_en, mem_wdata);
                        end else begin
                            e = exp_wr.pop_front();
                            chk("mem_write_txn", {mem_address, mem_byte_en, mem_wdata}, e[63:0]);
                            chk("mem_write_addr_hi", 64'(mem_address[31:28]), 64'(e[67:64]));
                        end
                        for (int i = 0; i < NB; i++)
                            if (mem_byte_en[i]) slv_mem[int'(mem_address) + i] = mem_wdata[8*i +: 8];
                        wr_done++;
                    end else begin
                        chk("stores_before_load", 64'(exp_wr.size()), 64'd0);
                        chk("load_byte_en", 64'(mem_byte_en), 64'hF);
                        if (exp_rd.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL mem_read_unexpected: got addr 0x%0h, required none", mem_address);
                        end else begin
                            chk("mem_read_addr", 64'(mem_address), 64'(exp_rd.pop_front()));
                        end
                        for (int i = 0; i < NB; i++) word[8*i +: 8] = slv_rd(int'(mem_address) + i);
                        mem_rdata = word;
                        rd_resp_cyc = cyc;
                    end
                    mem_resp = 1'b1;
                    busy = 0;
                end else begin
                    lat--;
                    waited = 1;
                end
            end
        end
    end

    // Output monitor: load results and misalign pulses.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                if (load_valid) begin
                    if (exp_ld.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL load_unexpected: got load_data 0x%0h, required no load", load_data);
                    end else begin
                        chk("load_data", 64'(load_data), 64'(exp_ld.pop_front()));
                    end
                    chk("load_latency", 64'(cyc), 64'(rd_resp_cyc + 1));
                end
                if (misalign) begin
                    if (exp_mis.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL misalign_unexpected: got pulse at addr 0x%0h, required none", req_addr);
                    end else begin
                        chk("misalign_addr", 64'(req_addr), 64'(exp_mis.pop_front()));
                    end
                    chk("misalign_no_read_stall", {62'd0, mem_read, stall}, 64'd0);
                end
            end
        end
    end

    // Issues one request: predicts its effect, then holds it until the DUT drops stall.
    task automatic issue(input bit rd, input bit wr, input bit bub, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input bit bub_mid,
                         output int waited);
        int nb, lane;
        bit act, bad;
        logic [31:0] alg;
        logic [63:0] v;
        nb   = 1 << f3[1:0];
        lane = int'(addr % 4);
        alg  = addr & ~32'd3;
        act  = (rd || wr) && !bub;
        bad  = (f3[1:0] == 2'd3) || ((addr % nb) != 0);
        if (act && bad) begin
            exp_mis.push_back(addr);
        end else if (act && wr) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
            exp_wr.push_back({alg, 4'(((1 << nb) - 1) << lane), 32'(wd << (8 * lane))});
        end else if (act && rd) begin
            v = 64'd0;
            for (int i = 0; i < nb; i++) v = v | (64'(ref_rd(int'(addr) + i)) << (8 * i));
            if (!f3[2] && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
            exp_rd.push_back(alg);
            exp_ld.push_back(v[31:0]);
        end
        req_read = rd; req_write = wr; is_bubbling = bub;
        req_funct3 = f3; req_addr = addr; req_wdata = wd;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bub_mid && mem_read) is_bubbling = 1'b1;
            if (!stall) break;
            waited++;
            if (waited > 300) begin
                checks++; errors++;
                $display("FAIL stall_timeout: got stall held %0d cycles at addr 0x%0h, required release", waited, addr);
                break;
            end
        end
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0; is_bubbling = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_count != 0 || mem_write || mem_read) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= 500), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_write(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_write && n < 50);
        chk(name, 64'(mem_write), 64'd1);
    endtask

    initial begin : stimulus
        int w, wd0;
        bit rd, wr, bub, bm;
        int kind, sz;
        logic [2:0]  f3;
        logic [31:0] a;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_in_rst", {stall, load_valid, misalign, sb_count, mem_read, mem_write},
            64'd0);
        chk("reset_bus_in_rst", {mem_address, mem_byte_en, mem_wdata[27:0]}, 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_outputs_after", {stall, load_valid, misalign, sb_count, mem_read, mem_write,
                                    mem_address[15:0]}, 64'd0);

        // Store halfword at 0x102: lane shift and byte enables
        issue(0, 1, 0, 3'b001, 32'h102, 32'hAABBCCDD, 0, w);
        chk("sh_no_stall", 64'(w), 64'd0);
        wait_write("sh_mem_write_seen");
        chk("sh_addr", 64'(mem_address), 64'h100);
        chk("sh_byte_en", 64'(mem_byte_en), 64'hC);
        chk("sh_wdata", 64'(mem_wdata), 64'hCCDD0000);
        wait_drain();

        // SB_DEPTH+1 back-to-back stores with slow memory: the last one waits for a pop
        fixed_lat = 4;
        wd0 = wr_done;
        for (int k = 0; k < SB_DEPTH; k++) begin
            issue(0, 1, 0, 3'b010, 32'h110 + 32'(4 * k), 32'h1000 + 32'(k), 0, w);
            chk("fill_no_stall", 64'(w), 64'd0);
        end
        chk("fill_count_full", 64'(sb_count), 64'(SB_DEPTH));
        chk("fill_no_pop_yet", 64'(wr_done - wd0), 64'd0);
        issue(0, 1, 0, 3'b010, 32'h110 + 32'(4 * SB_DEPTH), 32'h2000, 0, w);
        chk("full_store_stalled", 64'(w > 0), 64'd1);
        chk("full_store_after_pop", 64'(wr_done - wd0 >= 1), 64'd1);
        wait_drain();
        fixed_lat = -1;

        // Byte loads with sign and zero extension
        issue(0, 1, 0, 3'b010, 32'h100, 32'h80FFFFFF, 0, w);
        issue(1, 0, 0, 3'b000, 32'h103, 32'h0, 0, w);
        issue(1, 0, 0, 3'b100, 32'h103, 32'h0, 0, w);

        // Two stores then a load of the same word: stores drain first
        issue(0, 1, 0, 3'b010, 32'h104, 32'h11111111, 0, w);
        issue(0, 1, 0, 3'b010, 32'h104, 32'h22222222, 0, w);
        issue(1, 0, 0, 3'b010, 32'h104, 32'h0, 1, w);
        wait_drain();

        // Misaligned load, bubbled store
        issue(1, 0, 0, 3'b010, 32'h102, 32'h0, 0, w);
        chk("misalign_pulse_seen", 64'(exp_mis.size()), 64'd0);
        issue(0, 1, 1, 3'b010, 32'h108, 32'hDEADBEEF, 0, w);
        @(negedge clk);
        chk("bubble_no_push", {sb_count, mem_write}, 64'd0);
        @(posedge clk); #1;

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            sz   = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
            f3   = {1'($urandom_range(0, 1)), 2'(sz)};
            a    = 32'h100 + 32'($urandom_range(0, 63));
            if (kind != 9) a = a & ~(32'((1 << sz) - 1));
            rd = 0; wr = 0; bub = 0; bm = 0;
            if (kind <= 3) wr = 1;
            else if (kind <= 7) begin
                rd = 1;
                bm = ($urandom_range(0, 3) == 0);
            end else begin
                if ($urandom_range(0, 1) == 0) rd = 1; else wr = 1;
                bub = (kind == 8);
            end
            issue(rd, wr, bub, f3, a, $urandom, bm, w);
        end
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        chk("leftover_writes", 64'(exp_wr.size()), 64'd0);
        chk("leftover_reads", 64'(exp_rd.size()), 64'd0);
        chk("leftover_loads", 64'(exp_ld.size()), 64'd0);
        chk("leftover_misalign", 64'(exp_mis.size()), 64'd0);

        // Reset while draining: buffered stores are discarded
        fixed_lat = 20;
        issue(0, 1, 0, 3'b010, 32'h130, 32'h12345678, 0, w);
        issue(0, 1, 0, 3'b010, 32'h134, 32'h9ABCDEF0, 0, w);
        wait_write("drain_mem_write_seen");
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_drain_write", 64'(mem_write), 64'd0);
        chk("rst_mid_drain_count", 64'(sb_count), 64'd0);
        exp_wr.delete();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_discards_stores", {sb_count, mem_write, mem_read}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
